// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signals of the hazard controller (inputs from ID/EX, stall/flush controls and event counters).
interface hazard_ctrl_if;
    logic [31:0] instr_id_i;
    logic [4:0]  ex_rd_i;
    logic        ex_is_load_i;
    logic        br_taken_ex_i;
    logic        clr_cnt_i;
    logic        stall_pc_o;
    logic        stall_if_id_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
    modport master (
        output instr_id_i, ex_rd_i, ex_is_load_i, br_taken_ex_i, clr_cnt_i,
        input  stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o, stall_cnt_o, flush_cnt_o
    );
    modport slave (
        input  instr_id_i, ex_rd_i, ex_is_load_i, br_taken_ex_i, clr_cnt_i,
        output stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall / redirect flush control for a 5-stage RISC-V pipeline,
// with saturating stall and flush event counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALLS = 1
) (
    input logic         clk_i,
    input logic         rst_ni,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, STALL} state_t;
    state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [4:0] op, rs1, rs2;
    logic use1, use2, hz, stall, flush_if, flush_ex;
    logic [15:0] stall_cnt, flush_cnt;
    logic unused;
    assign op = bus.instr_id_i[6:2];
    assign rs1 = bus.instr_id_i[19:15];
    assign rs2 = bus.instr_id_i[24:20];
    assign unused = ^{bus.instr_id_i[31:25], bus.instr_id_i[14:7], bus.instr_id_i[1:0]};
    assign use2 = op inside {5'b11000, 5'b01000, 5'b01100};
    assign use1 = use2 || (op inside {5'b11001, 5'b00000, 5'b00100});
    assign hz = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) &&
                ((use1 && bus.ex_rd_i == rs1) || (use2 && bus.ex_rd_i == rs2));
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        stall = 1'b0;
        flush_if = 1'b0;
        flush_ex = 1'b0;
        if (bus.br_taken_ex_i) begin
            flush_if = 1'b1;
            flush_ex = 1'b1;
            state_n = RUN;
            cnt_n = 3'd0;
        end else if (state == STALL) begin
            stall = 1'b1;
            flush_ex = 1'b1;
            cnt_n = cnt - 3'd1;
            state_n = (cnt == 3'd1) ? RUN : STALL;
        end else if (hz) begin
            stall = 1'b1;
            flush_ex = 1'b1;
            state_n = (LOAD_STALLS > 1) ? STALL : RUN;
            cnt_n = (LOAD_STALLS > 1) ? 3'(LOAD_STALLS - 1) : 3'd0;
        end
    end
    // Outputs are gated by reset so they drop immediately, not at the next edge.
    assign bus.stall_pc_o    = rst_ni & stall;
    assign bus.stall_if_id_o = rst_ni & stall;
    assign bus.flush_if_id_o = rst_ni & flush_if;
    assign bus.flush_id_ex_o = rst_ni & flush_ex;
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.flush_cnt_o   = flush_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
            cnt <= 3'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else if (bus.clr_cnt_i) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            stall_cnt <= (stall && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
            flush_cnt <= (bus.br_taken_ex_i && flush_cnt != 16'hFFFF) ? flush_cnt + 16'd1 : flush_cnt;
        end
    end
endmodule
